xctcmsg_channel_mailbox: RTL and testbench

XCTCMSG_CHANNEL_MAILBOX -- requirements
Module: xctcmsg_channel_mailbox

---
 rtl/xctcmsg_pkg.sv | 24 ++
 rtl/xctcmsg_channel_fifo.sv | 68 ++++++
 rtl/xctcmsg_channel_mailbox.sv | 159 +++++++++++++++
 tb/tb_xctcmsg_channel_mailbox.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xctcmsg_pkg.sv
// Shared types for the channel mailbox.
//   exe_stage_passthrough_t : pipeline tag carried from request to writeback
//   channel_mailbox_state_t : receive FSM states
//   channel_mailbox_entry_t : stored message layout {sender, data} at the default payload width;
//                             the FIFOs hold the same {sender, data} packing at DATA_WIDTH
package xctcmsg_pkg;

    localparam int unsigned SENDER_W       = 32;
    localparam int unsigned DEFAULT_DATA_W = 64;

    typedef logic [15:0] exe_stage_passthrough_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } channel_mailbox_state_t;

    typedef struct packed {
        logic [SENDER_W-1:0]       sender;
        logic [DEFAULT_DATA_W-1:0] data;
    } channel_mailbox_entry_t;

endpackage

// File: rtl/xctcmsg_channel_fifo.sv
// One mailbox channel: circular FIFO with wrapping pointers and an occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write wdata_i (caller guarantees space or a same-cycle pop)
//   pop_i      : drop the head entry (caller guarantees non-empty)
//   rdata_o    : current head entry
//   count_o    : registered occupancy 0..DEPTH
module xctcmsg_channel_fifo
    import xctcmsg_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 96,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wptr_d  = push_i ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = pop_i  ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; empty slots are never presented as valid.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/xctcmsg_channel_mailbox.sv
// Multi-channel message mailbox with a single receive port.
//   net_*   : incoming messages {channel, sender, data}, back-pressured per channel
//   req_*   : receive requests (blocking / nonblocking) with pipeline passthrough
//   wb_*    : writeback result {value, sender, hit, passthrough}
//   flush   : cancels any in-flight receive request, stored messages are kept
//   chan_pending : per-channel non-empty flags from registered counts
module xctcmsg_channel_mailbox
    import xctcmsg_pkg::*;
#(
    parameter  int unsigned NUM_CHANNELS = 4,
    parameter  int unsigned DEPTH        = 4,
    parameter  int unsigned DATA_WIDTH   = 64,
    localparam int unsigned CH_W         = $clog2(NUM_CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    net_valid,
    output logic                    net_ready,
    input  logic [CH_W-1:0]         net_channel,
    input  logic [31:0]             net_sender,
    input  logic [DATA_WIDTH-1:0]   net_data,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [CH_W-1:0]         req_channel,
    input  logic                    req_nonblocking,
    input  exe_stage_passthrough_t  req_passthrough,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [DATA_WIDTH-1:0]   wb_value,
    output logic [31:0]             wb_sender,
    output logic                    wb_hit,
    output exe_stage_passthrough_t  wb_passthrough,
    output logic [NUM_CHANNELS-1:0] chan_pending
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = 32 + DATA_WIDTH;

    channel_mailbox_state_t state_q, state_d;
    logic                   hit_q, hit_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    exe_stage_passthrough_t pt_q, pt_d;

    logic [CNT_W-1:0]        count [NUM_CHANNELS];
    logic [ENTRY_W-1:0]      head  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] full, push, pop;
    logic [ENTRY_W-1:0]      head_sel;
    logic                    wb_hs;

    // flush overrides a same-cycle writeback handshake, so it also blocks the pop.
    assign wb_hs = (state_q == RESP) && wb_ready && !flush;

    always_comb begin
        full = '0;
        pop  = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            full[i] = (count[i] == CNT_W'(DEPTH));
            pop[i]  = wb_hs && hit_q && (ch_q == CH_W'(i));
        end
    end

    // A full channel still takes a push in the cycle its head is popped.
    assign net_ready = rst_n && (!full[net_channel] || pop[net_channel]);

    always_comb begin
        push = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            push[i] = net_valid && net_ready && (net_channel == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        xctcmsg_channel_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (ENTRY_W),
            .CNT_W (CNT_W)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (push[g]),
            .pop_i   (pop[g]),
            .wdata_i ({net_sender, net_data}),
            .rdata_o (head[g]),
            .count_o (count[g])
        );
        assign chan_pending[g] = (count[g] != '0);
    end

    // Channel occupancy is read from registered counts only: a message pushed
    // this cycle is seen by IDLE/WAIT one cycle later.
    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        ch_d    = ch_q;
        pt_d    = pt_q;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    ch_d = req_channel;
                    pt_d = req_passthrough;
                    if (count[req_channel] != '0) begin
                        state_d = RESP;
                        hit_d   = 1'b1;
                    end else if (req_nonblocking) begin
                        state_d = RESP;
                        hit_d   = 1'b0;
                    end else begin
                        state_d = WAIT;
                        hit_d   = 1'b0;
                    end
                end
            end
            WAIT: begin
                if (count[ch_q] != '0) begin
                    state_d = RESP;
                    hit_d   = 1'b1;
                end
            end
            RESP: begin
                if (wb_ready) begin
                    state_d = IDLE;
                    hit_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                hit_d   = 1'b0;
            end
        endcase
        if (flush) begin
            state_d = IDLE;
            hit_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hit_q   <= 1'b0;
            ch_q    <= '0;
            pt_q    <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            ch_q    <= ch_d;
            pt_q    <= pt_d;
        end
    end

    assign head_sel       = head[ch_q];
    assign req_ready      = (state_q == IDLE) && !flush;
    assign wb_valid       = (state_q == RESP);
    assign wb_hit         = hit_q;
    assign wb_value       = (wb_valid && hit_q) ? head_sel[DATA_WIDTH-1:0] : '0;
    assign wb_sender      = (wb_valid && hit_q) ? head_sel[ENTRY_W-1:DATA_WIDTH] : '0;
    assign wb_passthrough = pt_q;

endmodule

// File: tb/tb_xctcmsg_channel_mailbox.sv
module tb_xctcmsg_channel_mailbox;
    import xctcmsg_pkg::*;

    localparam int NCH = 4;
    localparam int DEP = 4;
    localparam int DW  = 64;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   flush;
    logic                   net_valid, net_ready;
    logic [1:0]             net_channel;
    logic [31:0]            net_sender;
    logic [DW-1:0]          net_data;
    logic                   req_valid, req_ready;
    logic [1:0]             req_channel;
    logic                   req_nonblocking;
    exe_stage_passthrough_t req_passthrough;
    logic                   wb_valid, wb_ready;
    logic [DW-1:0]          wb_value;
    logic [31:0]            wb_sender;
    logic                   wb_hit;
    exe_stage_passthrough_t wb_passthrough;
    logic [NCH-1:0]         chan_pending;

    xctcmsg_channel_mailbox #(
        .NUM_CHANNELS (NCH),
        .DEPTH        (DEP),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .net_valid       (net_valid),
        .net_ready       (net_ready),
        .net_channel     (net_channel),
        .net_sender      (net_sender),
        .net_data        (net_data),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_channel     (req_channel),
        .req_nonblocking (req_nonblocking),
        .req_passthrough (req_passthrough),
        .wb_valid        (wb_valid),
        .wb_ready        (wb_ready),
        .wb_value        (wb_value),
        .wb_sender       (wb_sender),
        .wb_hit          (wb_hit),
        .wb_passthrough  (wb_passthrough),
        .chan_pending    (chan_pending)
    );

    always #5 clk = ~clk;

    // Reference model: one message queue per channel plus a scoreboard of
    // outstanding receive responses (due = -1 while a blocking request waits).
    typedef struct {
        logic       hit;
        logic [1:0] ch;
        logic [15:0] pt;
        int         due;
    } exp_t;

    logic [95:0] mq [NCH][$];
    exp_t        sb [$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_bad = 0;
    int          acc_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    exp_t        e;
    logic [95:0] m;
    logic        busy, exp_valid, popping, exp_nr;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_wb_valid", 128'(wb_valid), 128'(0));
            chk("rst_wb_hit", 128'(wb_hit), 128'(0));
            chk("rst_wb_value", 128'(wb_value), 128'(0));
            chk("rst_wb_sender", 128'(wb_sender), 128'(0));
            chk("rst_chan_pending", 128'(chan_pending), 128'(0));
            chk("rst_net_ready", 128'(net_ready), 128'(0));
            for (int i = 0; i < NCH; i++) mq[i].delete();
            sb.delete();
        end else begin
            busy      = (sb.size() != 0);
            exp_valid = busy && (sb[0].due >= 0) && (cyc >= sb[0].due);
            chk("req_ready", 128'(req_ready), 128'(!busy && !flush));
            chk("wb_valid", 128'(wb_valid), 128'(exp_valid));
            for (int i = 0; i < NCH; i++)
                chk("chan_pending", 128'(chan_pending[i]), 128'(mq[i].size() != 0));
            popping = exp_valid && wb_ready && !flush && sb[0].hit;
            exp_nr  = (mq[net_channel].size() < DEP) || (popping && sb[0].ch == net_channel);
            chk("net_ready", 128'(net_ready), 128'(exp_nr));
            if (exp_valid) begin
                e = sb[0];
                m = e.hit ? mq[e.ch][0] : 96'd0;
                chk("wb_hit", 128'(wb_hit), 128'(e.hit));
                chk("wb_value", 128'(wb_value), 128'(m[63:0]));
                chk("wb_sender", 128'(wb_sender), 128'(m[95:64]));
                chk("wb_passthrough", 128'(wb_passthrough), 128'(e.pt));
            end
            // commit this cycle's events
            if (exp_valid && wb_ready && !flush) begin
                e = sb.pop_front();
                if (e.hit) void'(mq[e.ch].pop_front());
            end else if (flush && busy) begin
                void'(sb.pop_front());
            end
            if (sb.size() != 0 && sb[0].due < 0 && mq[sb[0].ch].size() != 0) begin
                e = sb.pop_front();
                e.due = cyc + 1;
                sb.push_front(e);
            end
            if (req_valid && !busy && !flush) begin
                e.ch = req_channel;
                e.pt = req_passthrough;
                if (mq[req_channel].size() != 0) begin
                    e.hit = 1'b1; e.due = cyc + 1;
                end else if (req_nonblocking) begin
                    e.hit = 1'b0; e.due = cyc + 1;
                end else begin
                    e.hit = 1'b1; e.due = -1;
                end
                sb.push_back(e);
                acc_cnt++;
            end
            if (net_valid && exp_nr) mq[net_channel].push_back({net_sender, net_data});
            cyc++;
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_msg(input logic [1:0] ch, input logic [31:0] s, input logic [63:0] d);
        net_valid = 1'b1; net_channel = ch; net_sender = s; net_data = d;
        step();
        net_valid = 1'b0;
    endtask

    task automatic do_req(input logic [1:0] ch, input logic nb);
        int start;
        bit got;
        start = acc_cnt;
        got = 0;
        req_valid = 1'b1; req_channel = ch; req_nonblocking = nb;
        req_passthrough = 16'($urandom);
        for (int i = 0; i < 50 && !got; i++) begin
            step();
            if (acc_cnt != start) got = 1;
        end
        req_valid = 1'b0;
        if (!got) begin
            n_chk++; n_bad++;
            $display("FAIL req_accept_timeout: got no accept expected accept on ch %0d", ch);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        net_valid = 1'b0; net_channel = '0; net_sender = '0; net_data = '0;
        req_valid = 1'b0; req_channel = '0; req_nonblocking = 1'b0; req_passthrough = '0;
        wb_ready = 1'b0;
        step(3);
        rst_n = 1'b1;
        wb_ready = 1'b1;
        step();

        // blocking hit on ch2
        push_msg(2, 32'h10, 64'hAA);
        do_req(2, 1'b0);
        step(3);
        // nonblocking miss on ch1
        do_req(1, 1'b1);
        step(3);
        // blocking wait on ch3, message arrives later
        do_req(3, 1'b0);
        step(3);
        push_msg(3, 32'h33, 64'h55);
        step(4);

        // fill ch0, back-pressure, then pop+push while full
        wb_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_msg(0, 32'h100 + i, 64'hC000 + i);
        net_channel = 2'd1; step();
        net_channel = 2'd0; step();
        push_msg(1, 32'h200, 64'hD000);
        do_req(0, 1'b0);
        step(2);
        wb_ready = 1'b1;
        push_msg(0, 32'h1FF, 64'hCFFF);
        for (int i = 0; i < 4; i++) do_req(0, 1'b0);
        do_req(1, 1'b0);
        step(3);

        // flush during RESP with wb_ready high: message stays, read again
        push_msg(1, 32'h300, 64'hE000);
        wb_ready = 1'b0;
        do_req(1, 1'b0);
        step(2);
        wb_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        do_req(1, 1'b0);
        step(3);

        // reset while waiting; stored message on ch0 is discarded
        push_msg(0, 32'h400, 64'hF000);
        do_req(2, 1'b0);
        step(2);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            net_valid       = ($urandom % 2) == 0;
            net_channel     = 2'($urandom);
            net_sender      = $urandom;
            net_data        = {$urandom, $urandom};
            req_valid       = ($urandom % 3) == 0;
            req_channel     = 2'($urandom);
            req_nonblocking = ($urandom % 4) == 0;
            req_passthrough = 16'($urandom);
            wb_ready        = (i < 1500) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
            flush           = ($urandom % 32) == 0;
            step();
        end
        net_valid = 1'b0; req_valid = 1'b0; flush = 1'b0; wb_ready = 1'b1;
        step(5);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
